// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter: round-robin share of one DMA engine port among N_REQ requesters
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid_i/read/addr/len_i  per-requester request; fields packed at [i*W +: W]
//   req_ready_o             one-hot accept pulse, issued the cycle after grant
//   req_done_o              one-hot completion pulse to the owner
//   dma_enable_o            one-cycle DMA start pulse
//   dma_read/addr/len_o     transfer fields latched at grant, held until next grant
//   dma_interrupt_i         DMA completion, honoured only while waiting
//   busy_o                  high whenever a transfer is in flight
//   grant_id_o              current or most recent owner
//   err_o, err_clr_i        sticky watchdog-timeout flag and its synchronous clear
module dma_req_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ-1:0]          req_read_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]    req_len_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [N_REQ-1:0]          req_done_o,
    output logic                      dma_enable_o,
    output logic                      dma_read_o,
    output logic [ADDR_W-1:0]         dma_addr_o,
    output logic [LEN_W-1:0]          dma_len_o,
    input  logic                      dma_interrupt_i,
    output logic                      busy_o,
    output logic [$clog2(N_REQ)-1:0]  grant_id_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [ID_W-1:0] win, rr_ptr;
    logic found, zero_len, timeout;
    logic [LEN_W-1:0] win_len;
    logic [WD_W-1:0] wdog;
    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid_i[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end
    assign win_len = req_len_i[win*LEN_W +: LEN_W];
    assign timeout = (TIMEOUT_CYC != 0) && (wdog == WD_W'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // zero-length grants still spend one ISSUE cycle (ready pulse, no enable) before DONE
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = found ? ISSUE : IDLE;
            ISSUE:   state_n = zero_len ? DONE : WAIT;
            WAIT:    state_n = (dma_interrupt_i || timeout) ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_o  <= '0;
            req_done_o   <= '0;
            dma_enable_o <= 1'b0;
            dma_read_o   <= 1'b0;
            dma_addr_o   <= '0;
            dma_len_o    <= '0;
            busy_o       <= 1'b0;
            grant_id_o   <= '0;
            err_o        <= 1'b0;
            rr_ptr       <= '0;
            zero_len     <= 1'b0;
            wdog         <= '0;
        end else begin
            req_ready_o  <= '0;
            req_done_o   <= '0;
            dma_enable_o <= 1'b0;
            busy_o       <= state_n != IDLE;
            wdog         <= (state == WAIT) ? wdog + 1'b1 : '0;
            if (state == IDLE && found) begin
                grant_id_o   <= win;
                rr_ptr       <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                dma_read_o   <= req_read_i[win];
                dma_addr_o   <= req_addr_i[win*ADDR_W +: ADDR_W];
                dma_len_o    <= win_len;
                zero_len     <= win_len == '0;
                req_ready_o  <= N_REQ'(1) << win;
                dma_enable_o <= win_len != '0;
            end
            // DONE is only reachable from ISSUE/WAIT, so grant_id_o already names the owner
            if (state_n == DONE) req_done_o <= N_REQ'(1) << grant_id_o;
            // a timeout outranks a simultaneous clear
            if (state == WAIT && !dma_interrupt_i && timeout) err_o <= 1'b1;
            else if (err_clr_i)                               err_o <= 1'b0;
        end
    end
endmodule
